elevator_car_controller: RTL

// - Car motion/door sequencer, directly downstream of the call memory manager: consumes its OCRequest/UDRequest and feeds back CurrentFloor, UDIn, Delay.
// - Times floor-to-floor travel and door dwell. Pulses an arrival strobe at each floor, then follows the manager's stop/continue decision.

---
 rtl/elevator_car_controller_pkg.sv | 28 ++
 rtl/elevator_car_controller_if.sv | 42 ++++
 rtl/elevator_car_controller_cycle_timer.sv | 35 +++
 rtl/elevator_car_controller.sv | 122 ++++++++++++
 4 files changed

// File: rtl/elevator_car_controller_pkg.sv
// Shared types and constants for the elevator car and its call-memory manager.
// Holds the FSM state encoding, floor width and the direction legality rule.
package elevator_pkg;

    localparam int FLOOR_W = 2;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_MOVE       = 3'd1,
        ST_DECIDE     = 3'd2,
        ST_DOOR_OPEN  = 3'd3,
        ST_DOOR_CLOSE = 3'd4
    } car_state_e;

    // A move is legal only if it keeps the car inside 0..top.
    function automatic logic move_legal(input logic [FLOOR_W-1:0] floor,
                                        input logic               up,
                                        input logic [FLOOR_W-1:0] top);
        if (up == DIR_UP) begin
            return (floor < top);
        end
        return (floor != '0);
    endfunction

endpackage

// File: rtl/elevator_car_controller_if.sv
// Request/status bundle between the call memory manager (master) and the car (slave).
interface elevator_car_controller_if;
    import elevator_pkg::*;

    logic               oc_request;
    logic               ud_request;
    logic               move_req;
    logic [FLOOR_W-1:0] current_floor;
    logic               dir_up;
    logic               arrive_pulse;
    logic               door_open;
    logic               motor_up;
    logic               motor_down;
    logic               busy;

    modport master (
        output oc_request,
        output ud_request,
        output move_req,
        input  current_floor,
        input  dir_up,
        input  arrive_pulse,
        input  door_open,
        input  motor_up,
        input  motor_down,
        input  busy
    );

    modport slave (
        input  oc_request,
        input  ud_request,
        input  move_req,
        output current_floor,
        output dir_up,
        output arrive_pulse,
        output door_open,
        output motor_up,
        output motor_down,
        output busy
    );

endinterface

// File: rtl/elevator_car_controller_cycle_timer.sv
// Loadable down-counter shared by travel and door phases; saturates at zero.
module cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/elevator_car_controller.sv
// Car motion/door sequencer: times travel and door dwell, strobes each arrival,
// then follows the manager's stop/continue decision sampled in DECIDE.
module elevator_car_controller
    import elevator_pkg::*;
#(
    parameter int TRAVEL_CYCLES = 16,
    parameter int DOOR_CYCLES   = 8,
    parameter int TOP_FLOOR     = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    elevator_car_controller_if.slave  car
);

    localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0]   TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0]   DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP         = FLOOR_W'(TOP_FLOOR);

    car_state_e         state_q, state_d;
    logic [FLOOR_W-1:0] floor_q, floor_d;
    logic               dir_q,   dir_d;

    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_value;
    logic               tmr_en;
    logic               tmr_done;
    logic               legal;

    cycle_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .en_i    (tmr_en),
        .done_o  (tmr_done)
    );

    assign legal  = move_legal(floor_q, car.ud_request, TOP);
    assign tmr_en = (state_q == ST_MOVE) || (state_q == ST_DOOR_OPEN) ||
                    (state_q == ST_DOOR_CLOSE);

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_d     = dir_q;
        tmr_load  = 1'b0;
        tmr_value = DOOR_LOAD;

        unique case (state_q)
            // IDLE and DECIDE share one decision; a stop request beats a move.
            ST_IDLE, ST_DECIDE: begin
                if (car.oc_request) begin
                    state_d   = ST_DOOR_OPEN;
                    tmr_load  = 1'b1;
                    tmr_value = DOOR_LOAD;
                end else if (car.move_req && legal) begin
                    state_d   = ST_MOVE;
                    dir_d     = car.ud_request;
                    tmr_load  = 1'b1;
                    tmr_value = TRAVEL_LOAD;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            ST_MOVE: begin
                if (tmr_done) begin
                    floor_d = (dir_q == DIR_UP) ? floor_q + 1'b1 : floor_q - 1'b1;
                    state_d = ST_DECIDE;
                end
            end

            ST_DOOR_OPEN: begin
                if (tmr_done) begin
                    state_d   = ST_DOOR_CLOSE;
                    tmr_load  = 1'b1;
                    tmr_value = DOOR_LOAD;
                end
            end

            ST_DOOR_CLOSE: begin
                if (car.oc_request) begin
                    state_d   = ST_DOOR_OPEN;
                    tmr_load  = 1'b1;
                    tmr_value = DOOR_LOAD;
                end else if (tmr_done) begin
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            floor_q <= '0;
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
        end
    end

    assign car.current_floor = floor_q;
    assign car.dir_up        = dir_q;
    assign car.arrive_pulse  = (state_q == ST_DECIDE);
    assign car.door_open     = (state_q == ST_DOOR_OPEN);
    assign car.motor_up      = (state_q == ST_MOVE) && (dir_q == DIR_UP);
    assign car.motor_down    = (state_q == ST_MOVE) && (dir_q == DIR_DOWN);
    assign car.busy          = (state_q != ST_IDLE);

endmodule
